// File: rtl/nv_afifo_pkg.sv
// ---------------------------------------------------------------------------
// nv_afifo_pkg
// Shared helpers for the asynchronous FIFO controllers (write and read side).
//
// Contents:
//   AFIFO_SYNC_STAGES : number of flops in the pointer-crossing synchronizer
//   bin2gray(bin, w)  : binary -> Gray conversion of a w-bit value
//   gray2bin(gray, w) : Gray -> binary conversion of a w-bit value
//
// The conversions operate on a 32-bit container. Callers zero-extend their
// pointer into it and truncate the result back to their own width. Bits at
// or above the width argument are forced to zero, so the same function
// serves any pointer width up to 32.
// ---------------------------------------------------------------------------
package nv_afifo_pkg;

    localparam int unsigned AFIFO_SYNC_STAGES = 2;
    localparam int unsigned AFIFO_MAX_PTR_W   = 32;

    function automatic logic [31:0] width_mask(input int unsigned width);
        logic [31:0] mask;
        if (width >= AFIFO_MAX_PTR_W) begin
            mask = '1;
        end else begin
            mask = (32'd1 << width) - 32'd1;
        end
        return mask;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin,
                                             input int unsigned width);
        logic [31:0] b;
        b = bin & width_mask(width);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it. With the
    // unused upper bits masked to zero, the top bit of the live field simply
    // passes through, so the loop can run over the whole container.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray,
                                             input int unsigned width);
        logic [31:0] bin;
        bin = gray & width_mask(width);
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i] ^ bin[i + 1];
        end
        return bin;
    endfunction

endpackage

// File: rtl/nv_afifo_sync2.sv
// ---------------------------------------------------------------------------
// nv_afifo_sync2
// Two-flop synchronizer used to bring a Gray-coded pointer from the other
// clock domain into the local one. Because only one bit of a Gray pointer
// changes per step, a bit sampled mid-transition resolves to either the old
// or the new pointer value, never to an unrelated one.
//
// Ports:
//   clk   : destination-domain clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : WIDTH-bit value from the source domain
//   q     : WIDTH-bit synchronized value, two clk cycles behind d
// ---------------------------------------------------------------------------
module nv_afifo_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage1_d;
    logic [WIDTH-1:0] stage2_q;
    logic [WIDTH-1:0] stage2_d;

    always_comb begin
        stage1_d = d;
        stage2_d = stage1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign q = stage2_q;

endmodule

// File: rtl/nv_afifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// nv_afifo_wr_ctrl
// Write-side pointer controller of an asynchronous FIFO. It owns the write
// pointer (binary and Gray), brings the read pointer across from the read
// domain, derives the full flag and the write-side occupancy, and produces
// the RAM write strobe/address plus the write-side clock-gate enable.
// There is no storage or payload path in here.
//
// Ports:
//   wr_clk         : write-domain clock
//   wr_reset_      : asynchronous active-low reset
//   wr_req         : producer write request
//   wr_busy        : FIFO full; writes are refused while high
//   rd_ptr_gray    : Gray read pointer from the read domain (asynchronous)
//   one_hot_enable : DFT one-hot clocking mode
//   tp             : DFT test-pattern phase
//   wr_en          : RAM write strobe (a write is accepted this cycle)
//   wr_adr         : RAM write address
//   wr_ptr_gray    : Gray write pointer toward the read domain
//   wr_count       : occupied entries as seen from the write side
//   wr_clk_en      : enable for the write-side RAM clock gate
//   wr_idle        : no request pending and no write in flight
// ---------------------------------------------------------------------------
module nv_afifo_wr_ctrl
    import nv_afifo_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          wr_clk,
    input  logic          wr_reset_,
    input  logic          wr_req,
    output logic          wr_busy,
    input  logic [AW:0]   rd_ptr_gray,
    input  logic          one_hot_enable,
    input  logic          tp,
    output logic          wr_en,
    output logic [AW-1:0] wr_adr,
    output logic [AW:0]   wr_ptr_gray,
    output logic [AW:0]   wr_count,
    output logic          wr_clk_en,
    output logic          wr_idle
);

    localparam int unsigned PW = AW + 1;

    // Full means the write pointer is exactly one lap ahead of the read
    // pointer. In Gray code that is the read pointer with its two MSBs
    // inverted and all lower bits equal.
    localparam logic [AW:0] FULL_MASK = PW'(3) << (AW - 1);

    logic [AW:0] wr_ptr_bin_q;
    logic [AW:0] wr_ptr_bin_d;
    logic [AW:0] wr_ptr_gray_q;
    logic [AW:0] wr_ptr_gray_d;
    logic        wr_en_d1_q;
    logic        wr_en_d1_d;

    logic [AW:0] rd_sync;
    logic [AW:0] rd_sync_bin;
    logic        accept;
    logic        func_en;

    // The read pointer is the only signal that crosses into this domain,
    // and this synchronizer is the only thing that samples it.
    nv_afifo_sync2 #(
        .WIDTH (PW)
    ) u_rd_sync (
        .clk   (wr_clk),
        .rst_n (wr_reset_),
        .d     (rd_ptr_gray),
        .q     (rd_sync)
    );

    // The full flag compares two registers only, so wr_req never has a
    // combinational path to wr_busy. The Gray pointer is recomputed from the
    // incremented binary pointer so that both registers move together.
    always_comb begin
        wr_busy       = (wr_ptr_gray_q == (rd_sync ^ FULL_MASK));
        accept        = wr_req & ~wr_busy;
        wr_ptr_bin_d  = wr_ptr_bin_q;
        wr_ptr_gray_d = wr_ptr_gray_q;
        if (accept) begin
            wr_ptr_bin_d  = wr_ptr_bin_q + PW'(1);
            wr_ptr_gray_d = PW'(bin2gray(32'(wr_ptr_bin_d), PW));
        end
        wr_en_d1_d    = accept;
    end

    // Occupancy uses modulo-2*DEPTH arithmetic on the extra-bit pointers;
    // it reads DEPTH exactly when the Gray comparison above reports full.
    always_comb begin
        rd_sync_bin = PW'(gray2bin(32'(rd_sync), PW));
        wr_count    = wr_ptr_bin_q - rd_sync_bin;
    end

    // The clock gate stays open for the cycle after a write so the RAM
    // captures it. In one-hot DFT mode it opens only during the test-pattern
    // phase, while the pointers keep running normally.
    always_comb begin
        func_en   = wr_req | wr_en_d1_q;
        wr_clk_en = func_en & (~one_hot_enable | tp);
        wr_idle   = ~wr_req & ~wr_en_d1_q;
        wr_en     = accept;
        wr_adr    = wr_ptr_bin_q[AW-1:0];
        wr_ptr_gray = wr_ptr_gray_q;
    end

    always_ff @(posedge wr_clk or negedge wr_reset_) begin
        if (!wr_reset_) begin
            wr_ptr_bin_q  <= '0;
            wr_ptr_gray_q <= '0;
            wr_en_d1_q    <= 1'b0;
        end else begin
            wr_ptr_bin_q  <= wr_ptr_bin_d;
            wr_ptr_gray_q <= wr_ptr_gray_d;
            wr_en_d1_q    <= wr_en_d1_d;
        end
    end

endmodule

// File: tb/tb_nv_afifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nv_afifo_wr_ctrl
// Self-checking bench for the write-side asynchronous FIFO controller with
// DEPTH=8. Expected values come from a small behavioural model that counts
// writes and reads as plain integers and delays the read count by two
// clock edges to mimic the pointer synchronizer.
// ---------------------------------------------------------------------------
module tb_nv_afifo_wr_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          wr_clk = 1'b0;
    logic          wr_reset_;
    logic          wr_req;
    logic          wr_busy;
    logic [AW:0]   rd_ptr_gray;
    logic          one_hot_enable;
    logic          tp;
    logic          wr_en;
    logic [AW-1:0] wr_adr;
    logic [AW:0]   wr_ptr_gray;
    logic [AW:0]   wr_count;
    logic          wr_clk_en;
    logic          wr_idle;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model state: total writes accepted, reads the read side has
    // published, and that read count as seen after one and two edges.
    int          mWrites;
    int          mRead;
    int          mSync1;
    int          mSync2;
    bit          mPrevAccept;
    logic [AW:0] prevGray;

    typedef struct {
        bit wrReq;
        bit oneHot;
        bit tpIn;
        bit expEn;
        bit expClkEn;
        bit expIdle;
        int expAdr;
        int expCount;
    } vecT;

    vecT vecs [9];

    nv_afifo_wr_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .wr_clk         (wr_clk),
        .wr_reset_      (wr_reset_),
        .wr_req         (wr_req),
        .wr_busy        (wr_busy),
        .rd_ptr_gray    (rd_ptr_gray),
        .one_hot_enable (one_hot_enable),
        .tp             (tp),
        .wr_en          (wr_en),
        .wr_adr         (wr_adr),
        .wr_ptr_gray    (wr_ptr_gray),
        .wr_count       (wr_count),
        .wr_clk_en      (wr_clk_en),
        .wr_idle        (wr_idle)
    );

    always #5 wr_clk = ~wr_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Gray code of a pointer value, taken modulo the pointer range.
    function automatic logic [AW:0] grayOf(input int v);
        logic [AW:0] b;
        b = (AW + 1)'(v % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic compare(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compares every output against the model for the current inputs.
    task automatic checkOutput();
        int occ;
        bit expBusy;
        occ     = mWrites - mSync2;
        expBusy = (occ == DEPTH);
        compare("wr_busy", int'(wr_busy), int'(expBusy));
        compare("wr_en", int'(wr_en), int'(wr_req && !expBusy));
        compare("wr_adr", int'(wr_adr), mWrites % DEPTH);
        compare("wr_ptr_gray", int'(wr_ptr_gray), int'(grayOf(mWrites)));
        compare("wr_count", int'(wr_count), occ);
        compare("wr_clk_en", int'(wr_clk_en),
                int'((wr_req || mPrevAccept) && (!one_hot_enable || tp)));
        compare("wr_idle", int'(wr_idle), int'(!wr_req && !mPrevAccept));
        if (wr_ptr_gray !== prevGray) begin
            compare("grayOneBit", $countones(wr_ptr_gray ^ prevGray), 1);
        end
        prevGray = wr_ptr_gray;
    endtask

    // One clock cycle: drive inputs, check mid-cycle, advance the model on
    // the rising edge, then leave 1 time unit so outputs settle.
    task automatic applyStimulus(input bit req, input bit oh, input bit tpIn);
        bit accept;
        wr_req         = req;
        one_hot_enable = oh;
        tp             = tpIn;
        rd_ptr_gray    = grayOf(mRead);
        @(negedge wr_clk);
        checkOutput();
        accept = req && ((mWrites - mSync2) != DEPTH);
        @(posedge wr_clk);
        if (accept) mWrites++;
        mPrevAccept = accept;
        mSync2      = mSync1;
        mSync1      = mRead;
        #1;
    endtask

    // Asserts reset away from any clock edge, checks that the outputs clear
    // immediately, then releases reset after two edges.
    task automatic doReset();
        wr_reset_      = 1'b0;
        wr_req         = 1'b0;
        one_hot_enable = 1'b0;
        tp             = 1'b0;
        rd_ptr_gray    = '0;
        mWrites        = 0;
        mRead          = 0;
        mSync1         = 0;
        mSync2         = 0;
        mPrevAccept    = 0;
        #1;
        compare("rstBusy", int'(wr_busy), 0);
        compare("rstCount", int'(wr_count), 0);
        compare("rstEn", int'(wr_en), 0);
        compare("rstAdr", int'(wr_adr), 0);
        compare("rstGray", int'(wr_ptr_gray), 0);
        compare("rstIdle", int'(wr_idle), 1);
        compare("rstClkEn", int'(wr_clk_en), 0);
        prevGray = '0;
        repeat (2) @(posedge wr_clk);
        #1;
        wr_reset_ = 1'b1;
    endtask

    initial begin
        int   cycles;
        logic [AW:0] grayHeld;

        // Hand-derived sequence from an empty FIFO with the read side idle.
        //           req oh tp  en clk idle adr cnt
        vecs[0] = '{0, 0, 0,  0, 0,  1,   0,  0};
        vecs[1] = '{1, 1, 0,  1, 0,  0,   0,  0};
        vecs[2] = '{0, 1, 1,  0, 1,  0,   1,  1};
        vecs[3] = '{0, 0, 0,  0, 0,  1,   1,  1};
        vecs[4] = '{1, 0, 0,  1, 1,  0,   1,  1};
        vecs[5] = '{0, 0, 0,  0, 1,  0,   2,  2};
        vecs[6] = '{1, 1, 1,  1, 1,  0,   2,  2};
        vecs[7] = '{1, 1, 0,  1, 0,  0,   3,  3};
        vecs[8] = '{0, 0, 0,  0, 1,  0,   4,  4};

        doReset();

        $display("[TB] table vectors");
        for (int i = 0; i < 9; i++) begin
            wr_req         = vecs[i].wrReq;
            one_hot_enable = vecs[i].oneHot;
            tp             = vecs[i].tpIn;
            rd_ptr_gray    = '0;
            @(negedge wr_clk);
            compare("vecEn", int'(wr_en), int'(vecs[i].expEn));
            compare("vecClkEn", int'(wr_clk_en), int'(vecs[i].expClkEn));
            compare("vecIdle", int'(wr_idle), int'(vecs[i].expIdle));
            compare("vecAdr", int'(wr_adr), vecs[i].expAdr);
            compare("vecCount", int'(wr_count), vecs[i].expCount);
            compare("vecBusy", int'(wr_busy), 0);
            @(posedge wr_clk);
            #1;
        end

        $display("[TB] fill to full");
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        @(negedge wr_clk);
        compare("fullBusy", int'(wr_busy), 1);
        compare("fullCount", int'(wr_count), DEPTH);
        compare("fullEn", int'(wr_en), 0);

        $display("[TB] hold request while full");
        grayHeld = wr_ptr_gray;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            compare("holdEn", int'(wr_en), 0);
            compare("holdGray", int'(wr_ptr_gray), int'(grayHeld));
            compare("holdIdle", int'(wr_idle), 0);
        end

        $display("[TB] release full by one read");
        mRead  = 1;
        cycles = 0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        cycles++;
        while (wr_busy && cycles < 3) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            cycles++;
        end
        compare("releaseBusy", int'(wr_busy), 0);
        compare("releaseCount", int'(wr_count), DEPTH - 1);
        wr_req = 1'b1;
        #1;
        compare("releaseAdr", int'(wr_adr), 0);
        compare("releaseEn", int'(wr_en), 1);
        applyStimulus(1'b1, 1'b0, 1'b0);

        $display("[TB] streaming with matched drain");
        doReset();
        for (int i = 0; i < 20; i++) begin
            mRead = mWrites;
            applyStimulus(1'b1, 1'b0, 1'b0);
            compare("countMax", int'(wr_count <= DEPTH), 1);
        end
        compare("streamWrites", mWrites, 20);

        $display("[TB] reset mid-burst");
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        compare("preResetCount", int'(wr_count), 5);
        #2;
        doReset();
        wr_req = 1'b1;
        #1;
        compare("postResetAdr", int'(wr_adr), 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        doReset();
        for (int i = 0; i < 600; i++) begin
            if (mRead < mWrites && $urandom_range(0, (i < 300) ? 2 : 1) == 0) begin
                mRead++;
            end
            applyStimulus($urandom_range(0, 3) != 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/nv_afifo_wr_ctrl.md
NV_AFIFO_WR_CTRL -- requirements
Module: nv_afifo_wr_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; power of two, minimum 2.
REQ-002 Parameter AW, default 3: address width, equal to log2(DEPTH).
REQ-003 Port wr_clk, input, 1: the single write-domain clock; all state in this block is clocked on its rising edge.
REQ-004 Port wr_reset_, input, 1: asynchronous, active-low reset.
REQ-005 Port wr_req, input, 1: producer write request.
REQ-006 Port wr_busy, output, 1: FIFO full; a write is accepted only when wr_req=1 and wr_busy=0.
REQ-007 Port rd_ptr_gray, input, AW+1: read pointer in Gray code, from the read clock domain (asynchronous to wr_clk).
REQ-008 Port one_hot_enable, input, 1: DFT one-hot clock mode select.
REQ-009 Port tp, input, 1: DFT test-pattern phase.
REQ-010 Port wr_en, output, 1: RAM write strobe.
REQ-011 Port wr_adr, output, AW: RAM write address.
REQ-012 Port wr_ptr_gray, output, AW+1: write pointer in Gray code, sent to the read domain.
REQ-013 Port wr_count, output, AW+1: occupied entries as seen from the write side.
REQ-014 Port wr_clk_en, output, 1: enable for the write-side RAM clock gate.
REQ-015 Port wr_idle, output, 1: no write is in flight and wr_req=0.

Function
REQ-016 accept = wr_req & ~wr_busy; wr_en SHALL equal accept, combinationally.
REQ-017 wr_adr SHALL equal wr_ptr_bin[AW-1:0], the current binary write pointer.
REQ-018 wr_ptr_bin (AW+1 bits) SHALL increment by 1 on the edge after accept and wrap from 2*DEPTH-1 to 0.
REQ-019 wr_ptr_gray SHALL be registered, equal to bin2gray(wr_ptr_bin), and update in the same cycle as wr_ptr_bin.
REQ-020 rd_ptr_gray SHALL pass through a 2-flop synchronizer to give rd_sync, with 2 wr_clk cycles of latency; no other logic may sample rd_ptr_gray.
REQ-021 wr_busy SHALL be 1 iff wr_ptr_gray equals rd_sync with its two MSBs inverted.
REQ-022 wr_busy SHALL depend only on registers, with no combinational path from wr_req.
REQ-023 wr_count SHALL equal (wr_ptr_bin - gray2bin(rd_sync)) mod 2*DEPTH, and SHALL equal DEPTH exactly when wr_busy=1.
REQ-024 A write and an rd_sync update in the same cycle: both SHALL take effect, and wr_count next = old count + 1 - the number of reads observed.
REQ-025 wr_req while wr_busy=1: no pointer change, wr_en=0; the producer holds the request.
REQ-026 wr_busy SHALL deassert 2 to 3 cycles after the read domain advances rd_ptr_gray out of the full condition.
REQ-027 wr_en_d1 SHALL be a register holding accept delayed by one cycle.
REQ-028 func_en = wr_req | wr_en_d1.
REQ-029 wr_clk_en = func_en & (~one_hot_enable | tp).
REQ-030 With one_hot_enable=1 and tp=0, wr_clk_en SHALL be 0 regardless of traffic, and pointers SHALL still update normally.
REQ-031 wr_idle = ~wr_req & ~wr_en_d1.

Reset
REQ-032 Assertion of wr_reset_ SHALL asynchronously clear wr_ptr_bin, wr_ptr_gray, both synchronizer stages, and wr_en_d1 to 0.
REQ-033 While in reset: wr_busy=0, wr_count=0, wr_en=0 when wr_req=0, wr_idle=1 when wr_req=0.
REQ-034 Reset mid-operation SHALL discard all pointer state; the read domain is reset concurrently by system convention.
REQ-035 Reset deassertion is synchronized outside this block; no internal reset synchronizer.

Structure
REQ-036 The bin2gray and gray2bin functions, parameterised on width, SHALL live in shared package nv_afifo_pkg, which is reused by the read-side controller.
REQ-037 The synchronizer SHALL be a separate sub-module nv_afifo_sync2 (width parameter, async active-low reset), instantiated once.
REQ-038 No RAM and no payload path inside this block; target size is 120 to 400 lines of RTL.

Verification (DEPTH=8)
REQ-039 Reset, then 8 back-to-back writes with rd_ptr_gray=0 -> wr_adr 0..7, wr_busy=1 on the cycle after the 8th accept, wr_count=8.
REQ-040 FIFO full, rd_ptr_gray driven to bin2gray(1) -> wr_busy=0 after 2 to 3 cycles, wr_count=7, and the next write goes to wr_adr 0.
REQ-041 Write 20 entries while the read side drains at the same rate -> wr_ptr_bin wraps 15 to 0, wr_ptr_gray changes exactly 1 bit per increment, and wr_count never exceeds 8.
REQ-042 one_hot_enable=1, tp=0 with wr_req=1 -> wr_clk_en=0. Set tp=1 -> wr_clk_en=1. one_hot_enable=0 -> wr_clk_en=func_en.
REQ-043 wr_reset_ asserted mid-burst with wr_count=5 -> all outputs reach their reset values immediately, without waiting for a clock edge, and the first write after release goes to wr_adr 0.
REQ-044 wr_req=1 held while full for 10 cycles -> wr_en=0 throughout, wr_ptr_gray stable, wr_idle=0.
